react_bcd_conv: RTL and testbench

//   Result-formatting stage between the reaction-time counter and the 4-digit
//   7-seg scan driver. Takes a binary reaction time (units of 0.1 ms), converts
//   it to 4 packed BCD digits with an iterative shift-add-3 engine, saturates
//   at 9999, and keeps a best (lowest) time register. Display outputs change

---
 rtl/react_bcd_conv.sv | 142 ++++++++++++++
 tb/tb_react_bcd_conv.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/react_bcd_conv.sv
// -----------------------------------------------------------------------------
// react_bcd_conv
//   Result-formatting stage between the reaction-time counter and the 4-digit
//   7-seg scan driver. A binary reaction time (0.1 ms units) is saturated at
//   9999 and converted to four packed BCD digits by an iterative shift-add-3
//   engine, one bit per clock. A best (lowest) time is kept alongside. The
//   display outputs only change when a conversion completes, so the scan
//   driver never shows a half-converted value.
//
// Ports
//   i_sysclk    in   1   system clock, rising edge
//   i_rst_n     in   1   asynchronous active-low reset
//   i_start     in   1   one-cycle request to convert i_bin_in (IDLE only)
//   i_bin_in    in   W   binary reaction time
//   i_clr_best  in   1   one-cycle request to forget the best time
//   o_bcd_out   out  16  last result {thou,hund,tens,ones}
//   o_best_bcd  out  16  best (lowest) result so far
//   o_busy      out  1   conversion in progress (SHIFT and FIN)
//   o_done      out  1   one-cycle pulse in the cycle the results update
//   o_ovf       out  1   last conversion saturated at 9999
// -----------------------------------------------------------------------------
module react_bcd_conv #(
    parameter int W = 14
) (
    input  logic         i_sysclk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [W-1:0] i_bin_in,
    input  logic         i_clr_best,
    output logic [15:0]  o_bcd_out,
    output logic [15:0]  o_best_bcd,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_ovf
);

    localparam int           CNT_W = $clog2(W + 1);
    localparam logic [W-1:0] SAT   = W'(9999);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_FIN
    } state_t;

    state_t           r_state;
    logic [W-1:0]     r_shreg;
    logic [W-1:0]     r_valBin;
    logic [15:0]      r_scratch;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovfPend;
    logic [W-1:0]     r_bestBin;
    logic [15:0]      r_bestBcd;
    logic [15:0]      r_bcdOut;
    logic             r_busy;
    logic             r_done;
    logic             r_ovf;

    logic [15:0]      w_adj;
    logic [W-1:0]     w_effBest;

    // Add-3 correction: any digit of 5 or more would exceed 9 after doubling,
    // so it is pre-biased by 3 to carry correctly into the next nibble.
    always_comb begin
        w_adj = r_scratch;
        for (int i = 0; i < 4; i++) begin
            if (r_scratch[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    // A clear arriving together with a completion is applied first, so the
    // completing result competes against the cleared value of 9999.
    assign w_effBest = i_clr_best ? SAT : r_bestBin;

    always_ff @(posedge i_sysclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_shreg   <= '0;
            r_valBin  <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_ovfPend <= 1'b0;
            r_bestBin <= SAT;
            r_bestBcd <= 16'h9999;
            r_bcdOut  <= 16'h0000;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_clr_best) begin
                r_bestBin <= SAT;
                r_bestBcd <= 16'h9999;
            end
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_shreg   <= (i_bin_in > SAT) ? SAT : i_bin_in;
                        r_valBin  <= (i_bin_in > SAT) ? SAT : i_bin_in;
                        r_ovfPend <= (i_bin_in > SAT);
                        r_scratch <= '0;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    {r_scratch, r_shreg} <= {w_adj, r_shreg} << 1;
                    r_cnt <= r_cnt + 1'b1;
                    // Raise done on the way into FIN so it is high during FIN.
                    if (r_cnt == CNT_W'(W - 1)) begin
                        r_state <= S_FIN;
                        r_done  <= 1'b1;
                    end
                end
                S_FIN: begin
                    r_bcdOut <= r_scratch;
                    r_ovf    <= r_ovfPend;
                    if (r_valBin < w_effBest) begin
                        r_bestBin <= r_valBin;
                        r_bestBcd <= r_scratch;
                    end
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_bcd_out  = r_bcdOut;
    assign o_best_bcd = r_bestBcd;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_ovf      = r_ovf;

endmodule

// File: tb/tb_react_bcd_conv.sv
// -----------------------------------------------------------------------------
// tb_react_bcd_conv
//   Directed scoreboard bench for react_bcd_conv. Each request pushes its
//   hand-computed result into a queue; a monitor pops and compares whenever
//   the DUT pulses done.
// -----------------------------------------------------------------------------
module tb_react_bcd_conv;

    localparam int W = 14;

    logic         sysclk;
    logic         rstN;
    logic         start;
    logic [W-1:0] binIn;
    logic         clrBest;
    logic [15:0]  bcdOut;
    logic [15:0]  bestBcd;
    logic         busy;
    logic         done;
    logic         ovf;

    typedef struct {
        logic [15:0] bcd;
        logic [15:0] best;
        logic        ovf;
    } exp_t;

    exp_t expQ[$];
    int   assertCount = 0;
    int   failCount   = 0;
    int   pushCount   = 0;
    int   doneCount   = 0;

    react_bcd_conv #(.W(W)) dut (
        .i_sysclk   (sysclk),
        .i_rst_n    (rstN),
        .i_start    (start),
        .i_bin_in   (binIn),
        .i_clr_best (clrBest),
        .o_bcd_out  (bcdOut),
        .o_best_bcd (bestBcd),
        .o_busy     (busy),
        .o_done     (done),
        .o_ovf      (ovf)
    );

    // 10 ns clock
    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // Hard stop in case something never settles
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
        assertCount++;
        if (act !== req) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic pushExp(input logic [15:0] b, input logic [15:0] bst, input logic o);
        exp_t e;
        e.bcd  = b;
        e.best = bst;
        e.ovf  = o;
        expQ.push_back(e);
        pushCount++;
    endtask

    // Monitor: results are compared one cycle after done, once they are loaded
    always @(negedge sysclk) begin
        if (done === 1'b1) begin
            exp_t e;
            doneCount++;
            if (expQ.size() == 0) begin
                checkOutput("doneWithoutRequest", 16'(expQ.size()), 16'd1);
            end else begin
                e = expQ.pop_front();
                @(negedge sysclk);
                checkOutput("bcdOut", bcdOut, e.bcd);
                checkOutput("bestBcd", bestBcd, e.best);
                checkOutput("ovf", 16'(ovf), 16'(e.ovf));
                checkOutput("donePulseWidth", 16'(done), 16'd0);
            end
        end
    end

    task automatic doReset();
        rstN = 1'b0;
        repeat (2) @(negedge sysclk);
        rstN = 1'b1;
        @(negedge sysclk);
    endtask

    // Issue one conversion, check latency, optionally pulse clr_best in FIN.
    // Returns at the negedge of the first cycle a new start is accepted.
    task automatic applyStimulus(input logic [W-1:0] bin, input logic [15:0] expBcd,
                                 input logic [15:0] expBest, input logic expOvf,
                                 input logic clrAtFin);
        int k;
        pushExp(expBcd, expBest, expOvf);
        start = 1'b1;
        binIn = bin;
        for (k = 1; k <= 40; k++) begin
            @(negedge sysclk);
            if (k == 1) start = 1'b0;
            if (done === 1'b1) break;
        end
        checkOutput("latency", 16'(k), 16'd15);
        if (clrAtFin) clrBest = 1'b1;
        @(negedge sysclk);
        clrBest = 1'b0;
    endtask

    initial begin
        int busyCnt;
        int doneCyc;
        rstN    = 1'b0;
        start   = 1'b0;
        binIn   = '0;
        clrBest = 1'b0;
        repeat (2) @(negedge sysclk);

        // Reset state
        checkOutput("rstBcd", bcdOut, 16'h0000);
        checkOutput("rstBest", bestBcd, 16'h9999);
        checkOutput("rstBusy", 16'(busy), 16'd0);
        checkOutput("rstDone", 16'(done), 16'd0);
        checkOutput("rstOvf", 16'(ovf), 16'd0);
        rstN = 1'b1;
        @(negedge sysclk);

        // Zero input
        applyStimulus(14'd0, 16'h0000, 16'h0000, 1'b0, 1'b0);

        // Best tracking
        doReset();
        applyStimulus(14'd1234, 16'h1234, 16'h1234, 1'b0, 1'b0);
        applyStimulus(14'd2500, 16'h2500, 16'h1234, 1'b0, 1'b0);
        applyStimulus(14'd987,  16'h0987, 16'h0987, 1'b0, 1'b0);

        // Saturation and boundary values
        doReset();
        applyStimulus(14'd12000, 16'h9999, 16'h9999, 1'b1, 1'b0);
        applyStimulus(14'd5,     16'h0005, 16'h0005, 1'b0, 1'b0);
        applyStimulus(14'd9999,  16'h9999, 16'h0005, 1'b0, 1'b0);
        applyStimulus(14'd16383, 16'h9999, 16'h0005, 1'b1, 1'b0);

        // Starts while busy are ignored; outputs hold until done
        pushExp(16'h4321, 16'h0005, 1'b0);
        busyCnt = 0;
        doneCyc = 0;
        start = 1'b1;
        binIn = 14'd4321;
        for (int c = 1; c <= 20; c++) begin
            @(negedge sysclk);
            if (c == 1 || c == 4 || c == 9) start = 1'b0;
            if (c == 3 || c == 8) begin
                start = 1'b1;
                binIn = 14'd7;
            end
            if (busy === 1'b1) busyCnt++;
            if (done === 1'b1) doneCyc = c;
            if (c == 5) begin
                checkOutput("holdBcd", bcdOut, 16'h9999);
                checkOutput("holdOvf", 16'(ovf), 16'd1);
            end
        end
        checkOutput("busyCycles", 16'(busyCnt), 16'd15);
        checkOutput("doneCycle", 16'(doneCyc), 16'd15);

        // clr_best coincident with FIN, then alone
        doReset();
        applyStimulus(14'd300, 16'h0300, 16'h0300, 1'b0, 1'b0);
        applyStimulus(14'd450, 16'h0450, 16'h0450, 1'b0, 1'b1);
        clrBest = 1'b1;
        @(negedge sysclk);
        clrBest = 1'b0;
        checkOutput("clrBestAlone", bestBcd, 16'h9999);

        // Asynchronous reset mid-conversion
        applyStimulus(14'd100, 16'h0100, 16'h0100, 1'b0, 1'b0);
        start = 1'b1;
        binIn = 14'd2222;
        for (int c = 1; c <= 7; c++) begin
            @(negedge sysclk);
            if (c == 1) start = 1'b0;
        end
        checkOutput("midBusy", 16'(busy), 16'd1);
        rstN = 1'b0;
        #1;
        checkOutput("asyncBusy", 16'(busy), 16'd0);
        checkOutput("asyncDone", 16'(done), 16'd0);
        checkOutput("asyncBcd", bcdOut, 16'h0000);
        checkOutput("asyncBest", bestBcd, 16'h9999);
        checkOutput("asyncOvf", 16'(ovf), 16'd0);
        repeat (2) @(negedge sysclk);
        rstN = 1'b1;
        repeat (25) @(negedge sysclk);

        checkOutput("scoreboardEmpty", 16'(expQ.size()), 16'd0);
        checkOutput("doneCount", 16'(doneCount), 16'(pushCount));

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
